yarp_instr_fetch: RTL
=====================

YARP_INSTR_FETCH -- requirements
Module: yarp_instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_1000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 imem_req_o  out  1  instruction-memory request valid.
REQ-005 imem_addr_o  out  32  request byte address.
REQ-006 imem_gnt_i  in  1  request accepted this cycle.
REQ-007 imem_rvalid_i  in  1  read data valid.
REQ-008 imem_rdata_i  in  32  fetched instruction word.
REQ-009 branch_taken_i  in  1  redirect strobe, driven by branch control / jump logic.
REQ-010 branch_target_i  in  32  redirect target PC.
REQ-011 instr_valid_o  out  1  instruction available to decode.
REQ-012 instr_o  out  32  held instruction.
REQ-013 instr_pc_o  out  32  PC of instr_o.
REQ-014 instr_ready_i  in  1  decode accepts instr_o this cycle.
REQ-015 fetch_misaligned_o  out  1  sticky misaligned-target flag (see Configuration).

Function
REQ-016 FSM states: IDLE, REQ, WAIT, HOLD; one outstanding request maximum.
REQ-017 IDLE: outputs inactive; exits to REQ the cycle after reset_n deasserts.
REQ-018 REQ: imem_req_o=1, imem_addr_o=pc_q; gnt -> WAIT; else stay.
REQ-019 WAIT: imem_req_o=0; rvalid -> capture rdata into instr_o, pc_q into instr_pc_o -> HOLD.
REQ-020 HOLD: instr_valid_o=1, instr_o/instr_pc_o stable; instr_ready_i -> pc_q <= pc_q+4 -> REQ.
REQ-021 Minimum latency: gnt in cycle N, rvalid in N+1, instr_valid_o in N+2.
REQ-022 pc_q+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-023 Redirect (branch_taken_i=1) in any state: pc_q <= branch_target_i next edge; priority over instr_ready_i.
REQ-024 Redirect in REQ without gnt: stay REQ, imem_addr_o = target next cycle.
REQ-025 Redirect in REQ with gnt, or in WAIT before rvalid: set kill_q, enter/stay WAIT; matching rvalid discarded, clears kill_q, -> REQ at target.
REQ-026 Redirect in WAIT coincident with rvalid: response discarded, -> REQ at target.
REQ-027 Redirect in HOLD: held instruction dropped, instr_valid_o=0 next cycle, -> REQ.
REQ-028 imem_rvalid_i outside WAIT is ignored.

Reset
REQ-029 reset_n low, any state: state=IDLE, pc_q=RESET_PC, kill_q=0, imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, fetch_misaligned_o=0, immediately (asynchronous).
REQ-030 Responses arriving after reset release for pre-reset requests are ignored (REQ-028).

Configuration
REQ-031 Macro YARP_FETCH_MISALIGN_EN defined: redirect with target[1:0]!=2'b00 does not redirect; fetch_misaligned_o set sticky next edge, FSM -> IDLE and halts until reset.
REQ-032 Macro undefined: target[1:0] forced to 2'b00 on redirect; fetch_misaligned_o tied 0.

Structure
REQ-033 yarp_pkg holds fetch_state_t enum (IDLE/REQ/WAIT/HOLD) and constant PC_INCR=32'd4.
REQ-034 Single module, no sub-module; pc register, kill flag, FSM and output registers in-line.

Verification
REQ-035 Reset, gnt and rvalid always 1 -> addresses 0x1000, 0x1004, 0x1008 in consecutive fetches; instr_valid_o first high 2 cycles after first gnt.
REQ-036 instr_ready_i=0 for 5 cycles in HOLD -> instr_o/instr_pc_o stable, imem_req_o=0 throughout.
REQ-037 Redirect to 0x2000 in WAIT, rvalid next cycle with 0xDEADBEEF -> word discarded, next imem_addr_o=0x2000, instr_pc_o of next valid = 0x2000.
REQ-038 pc_q=0xFFFF_FFFC accepted -> next imem_addr_o=0x0000_0000.
REQ-039 With YARP_FETCH_MISALIGN_EN, redirect to 0x2002 -> fetch_misaligned_o=1 next cycle, imem_req_o=0 until reset; without macro -> fetch from 0x2000.
REQ-040 reset_n pulsed low while in WAIT, stale rvalid after release -> ignored, first fetch at RESET_PC.

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared types and constants for the YARP instruction fetch unit.
// Holds the fetch FSM state encoding and the sequential PC increment.
package yarp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_INCR = 32'd4;

    // Clear the two byte-offset bits of a byte address.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/yarp_instr_fetch.sv
// YARP instruction fetch: one outstanding imem request, redirect/kill, hold.
// Optional YARP_FETCH_MISALIGN_EN: misaligned redirect halts with sticky flag.
module yarp_instr_fetch
    import yarp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        fetch_misaligned_o
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        kill_q;
    logic        kill_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] ipc_q;
    logic [31:0] ipc_d;

    logic [31:0] target;
    logic        redirect_bad;
    logic        redirect_ok;
    logic        mis_q;

`ifdef YARP_FETCH_MISALIGN_EN
    logic mis_d;

    assign target       = branch_target_i;
    assign redirect_bad = branch_taken_i && !mis_q
                          && (branch_target_i[1:0] != 2'b00);

    // Misaligned flag is sticky until reset.
    always_comb begin
        mis_d = mis_q;
        if (redirect_bad) begin
            mis_d = 1'b1;
        end
    end

    // Sticky misaligned-target register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
`else
    assign target       = align_word(branch_target_i);
    assign redirect_bad = 1'b0;
    assign mis_q        = 1'b0;
`endif

    assign redirect_ok = branch_taken_i && !redirect_bad && !mis_q;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a bad redirect parks the unit in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!mis_q && !redirect_bad) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_bad) begin
                    state_d = IDLE;
                end else if (imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_bad) begin
                    state_d = IDLE;
                end else if (imem_rvalid_i) begin
                    if (kill_q || redirect_ok) begin
                        state_d = REQ;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_bad) begin
                    state_d = IDLE;
                end else if (redirect_ok || instr_ready_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        imem_req_o    = 1'b0;
        imem_addr_o   = 32'h0;
        instr_valid_o = 1'b0;
        unique case (state_q)
            REQ: begin
                imem_req_o  = 1'b1;
                imem_addr_o = pc_q;
            end
            HOLD: begin
                instr_valid_o = 1'b1;
            end
            default: begin
                imem_req_o = 1'b0;
            end
        endcase
    end

    // PC, kill flag and instruction buffer next values.
    always_comb begin
        pc_d    = pc_q;
        kill_d  = kill_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;

        if (redirect_ok) begin
            pc_d = target;
        end else if (state_q == HOLD && instr_ready_i) begin
            pc_d = pc_q + PC_INCR;
        end

        unique case (state_q)
            REQ: begin
                if (redirect_ok && imem_gnt_i) begin
                    kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    kill_d = 1'b0;
                    if (!kill_q && !redirect_ok) begin
                        instr_d = imem_rdata_i;
                        ipc_d   = pc_q;
                    end
                end else if (redirect_ok) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                kill_d = 1'b0;
            end
        endcase

        if (redirect_bad) begin
            kill_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            instr_q <= 32'h0;
            ipc_q   <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    assign instr_o            = instr_q;
    assign instr_pc_o         = ipc_q;
    assign fetch_misaligned_o = mis_q;

endmodule
